prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
- Parameters:
  - REQ-001 N, default 12, program-memory address width.
  - REQ-002 M, default 8, program word width; also the byte width of the input stream.
  - REQ-003 DEPTH, default 21, number of program-memory words available.
- Ports:
  - REQ-004 clock  in  1  sole clock; all state changes on its rising edge.
  - REQ-005 reset  in  1  synchronous, active-high reset.
  - REQ-006 start  in  1  single-cycle request to begin a load.
  - REQ-007 in_valid  in  1  in_data holds a byte.
  - REQ-008 in_data  in  M  stream byte: length, then program words, then checksum.
  - REQ-009 in_ready  out  1  loader can accept a byte this cycle.
  - REQ-010 wr_en  out  1  one-cycle program-memory write strobe.
  - REQ-011 wr_addr  out  N  program-memory write address.
  - REQ-012 wr_data  out  M  program-memory write data.
  - REQ-013 cpu_hold  out  1  holds the processor PC/fetch while a load is in progress.
  - REQ-014 done  out  1  last load completed with a good checksum.
  - REQ-015 err  out  1  last load aborted: bad length or checksum mismatch.
  - REQ-016 checksum  out  M  running mod-2^M sum of accepted program words.

Function
- REQ-017 States: IDLE, LEN, DATA, CHK, DONE, ERR.
- REQ-018 A byte is accepted only in a cycle where in_valid=1 and in_ready=1.
- REQ-019 in_ready=1 exactly in LEN, DATA, CHK.
- REQ-020 IDLE/DONE/ERR with start=1 -> LEN next cycle; same edge clears done, err, checksum, the word counter and the address counter.
- REQ-021 start in LEN/DATA/CHK ignored.
- REQ-022 LEN: accepted byte L is latched.
  - L=0 or L>DEPTH -> ERR.
  - Otherwise -> DATA.
- REQ-023 DATA, each accepted byte:
  - next cycle wr_en=1, wr_addr = current address counter, wr_data = byte;
  - checksum += byte mod 2^M;
  - address counter +1;
  - word counter +1.
- REQ-024 wr_en SHALL be 1 for exactly one cycle per accepted DATA byte and 0 otherwise; the write latency after acceptance is fixed at 1 cycle.
- REQ-025 DATA -> CHK on the edge that accepts the L-th word.
- REQ-026 CHK, accepted byte:
  - equals checksum (including the L-th word) -> DONE;
  - else -> ERR.
- REQ-027 Outputs by state:
  - DONE: done=1, err=0.
  - ERR: err=1, done=0.
  - DONE and ERR hold until the next start or reset.
- REQ-028 cpu_hold=1 in LEN, DATA, CHK, and during the final wr_en cycle; 0 otherwise.
- REQ-029 The address counter wraps 2^N-1 -> 0 (only reachable if DEPTH=2^N); no write is issued beyond L words.
- REQ-030 in_valid=0 in LEN/DATA/CHK stalls the loader indefinitely with no state change.
- REQ-031 wr_addr and wr_data hold their last written values while wr_en=0.

Reset
- REQ-032 On reset=1 at a clock edge:
  - state -> IDLE;
  - in_ready, wr_en, cpu_hold, done, err = 0;
  - wr_addr, wr_data, checksum, counters = 0.
- REQ-033 Reset takes precedence over start and over any simultaneous byte acceptance, including mid-DATA; any write scheduled for the following cycle is cancelled.

Verification
- REQ-034 Good load:
  - stimulus: start; bytes 03, 41, 52, 13, A6.
  - response: writes (0,41), (1,52), (2,13); done=1, err=0, checksum=A6.
- REQ-035 Bad checksum:
  - stimulus: start; bytes 02, 10, 20, 31.
  - response: writes (0,10), (1,20); err=1, done=0, checksum=30.
- REQ-036 Bad length:
  - stimulus: start; 00 -> err=1, no wr_en.
  - stimulus: start; 16 (22 > DEPTH) -> err=1, no wr_en.
- REQ-037 Stall and overflow:
  - stimulus: start; 02, FF, then in_valid low 5 cycles, then 02, 01.
  - response: cpu_hold=1 throughout the stall; writes (0,FF), (1,02); checksum wraps to 01; done=1.
- REQ-038 Reset mid-load:
  - stimulus: start; 03, 41, then reset asserted in the cycle 52 is accepted.
  - response: no write of 52; all outputs 0; state IDLE.
- REQ-039 Ignored start:
  - stimulus: start pulsed again while in DATA.
  - response: no effect; the load completes normally.

Source files
------------

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Streams a program image from a byte interface into program memory while the
// processor is held off. The stream format is: one length byte L, then L
// program words, then one checksum byte. The checksum is the mod-2^M sum of the
// L program words. A load ends in DONE when the checksum matches, or in ERR
// when the length is out of range or the checksum does not match.
//
// Parameters
//   N      program-memory address width
//   M      program word width, also the width of a stream byte
//   DEPTH  number of program-memory words available (valid L is 1..DEPTH)
//
// Ports
//   clock     sole clock, all state changes on the rising edge
//   reset     synchronous, active-high reset
//   start     single-cycle request to begin a load (ignored mid-load)
//   in_valid  in_data holds a byte
//   in_data   stream byte: length, program words, checksum
//   in_ready  loader accepts a byte this cycle (LEN, DATA, CHK)
//   wr_en     one-cycle program-memory write strobe
//   wr_addr   program-memory write address (holds while wr_en=0)
//   wr_data   program-memory write data (holds while wr_en=0)
//   cpu_hold  holds processor fetch while a load is in progress
//   done      last load completed with a good checksum
//   err       last load aborted: bad length or checksum mismatch
//   checksum  running mod-2^M sum of accepted program words
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int N     = 12,
    parameter int M     = 8,
    parameter int DEPTH = 21
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         in_valid,
    input  logic [M-1:0] in_data,
    output logic         in_ready,
    output logic         wr_en,
    output logic [N-1:0] wr_addr,
    output logic [M-1:0] wr_data,
    output logic         cpu_hold,
    output logic         done,
    output logic         err,
    output logic [M-1:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t       state;
    logic [M-1:0] length;
    logic [M-1:0] word_cnt;
    logic [N-1:0] addr_cnt;
    logic         accept;

    // Status outputs are pure decodes of the state register, so they change
    // only on clock edges and need no separate clearing logic.
    assign in_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
    assign done     = (state == S_DONE);
    assign err      = (state == S_ERR);
    // The write strobe trails the accepting edge by one cycle, so the hold is
    // stretched over that final write as well.
    assign cpu_hold = in_ready || wr_en;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clock) begin
        // NOTE: reset is sampled on the clock edge (synchronous); it is checked
        // first so it overrides start and any byte accepted on the same edge,
        // which also cancels a write that would otherwise follow.
        if (reset) begin
            state    <= S_IDLE;
            length   <= '0;
            word_cnt <= '0;
            addr_cnt <= '0;
            checksum <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register sees the pre-edge values of the others; the default
            // below is then overridden by the DATA branch when a word lands.
            wr_en <= 1'b0;

            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state    <= S_LEN;
                        checksum <= '0;
                        word_cnt <= '0;
                        addr_cnt <= '0;
                    end
                end

                S_LEN: begin
                    if (accept) begin
                        length <= in_data;
                        if (in_data == '0 || int'(in_data) > DEPTH) begin
                            state <= S_ERR;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (accept) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= addr_cnt;
                        wr_data  <= in_data;
                        checksum <= checksum + in_data;
                        addr_cnt <= addr_cnt + 1'b1;
                        word_cnt <= word_cnt + 1'b1;
                        // Leave DATA on the edge that takes the L-th word so no
                        // write is ever issued beyond L.
                        if (word_cnt + 1'b1 == length) begin
                            state <= S_CHK;
                        end
                    end
                end

                S_CHK: begin
                    // The checksum register already includes the L-th word,
                    // which was added on the edge that entered this state.
                    if (accept) begin
                        state <= (in_data == checksum) ? S_DONE : S_ERR;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Directed bench for prog_loader. Inputs are driven on the falling edge and
// outputs are sampled on the falling edge; a monitor logs every program-memory
// write so the write sequence of each load can be compared against
// hand-computed expected (address, data) pairs.
// -----------------------------------------------------------------------------
module tb_prog_loader;

    localparam int N     = 12;
    localparam int M     = 8;
    localparam int DEPTH = 21;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         in_valid;
    logic [M-1:0] in_data;
    logic         in_ready;
    logic         wr_en;
    logic [N-1:0] wr_addr;
    logic [M-1:0] wr_data;
    logic         cpu_hold;
    logic         done;
    logic         err;
    logic [M-1:0] checksum;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] log_addr[$];
    logic [M-1:0] log_data[$];

    prog_loader #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err),
        .checksum (checksum)
    );

    always #5 clock = ~clock;

    // Write monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (wr_en === 1'b1) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one byte starting at a falling edge; returns at the falling edge
    // after the rising edge that accepted it.
    task automatic put_byte(input logic [M-1:0] b);
        bit taken = 0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 20 && !taken; i++) begin
            if (in_ready === 1'b1) taken = 1;
            @(negedge clock);
        end
        in_valid = 1'b0;
        if (!taken) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        log_addr.delete();
        log_data.delete();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic check_writes(input string tag, input logic [M-1:0] exp_data[$]);
        check({tag, "_count"}, log_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < log_data.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), log_addr[i], i);
            check($sformatf("%s_data%0d", tag, i), log_data[i], exp_data[i]);
        end
    endtask

    initial begin
        logic [M-1:0] exp_q[$];
        logic [M-1:0] sum;

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(negedge clock);

        // Reset state
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_en",    wr_en,    0);
        check("rst_cpu_hold", cpu_hold, 0);
        check("rst_done",     done,     0);
        check("rst_err",      err,      0);
        check("rst_checksum", checksum, 0);
        check("rst_wr_addr",  wr_addr,  0);
        check("rst_wr_data",  wr_data,  0);
        reset = 1'b0;
        @(negedge clock);

        // Good load: 03 41 52 13 A6
        pulse_start();
        check("good_in_ready_len", in_ready, 1);
        check("good_hold_len",     cpu_hold, 1);
        put_byte(8'h03);
        put_byte(8'h41);
        check("good_wr_latency", wr_en, 1);
        put_byte(8'h52);
        put_byte(8'h13);
        put_byte(8'hA6);
        @(negedge clock);
        exp_q = '{8'h41, 8'h52, 8'h13};
        check_writes("good", exp_q);
        check("good_done",     done,     1);
        check("good_err",      err,      0);
        check("good_checksum", checksum, 8'hA6);
        check("good_hold_end", cpu_hold, 0);
        check("good_ready_end", in_ready, 0);
        check("good_hold_addr", wr_addr, 2);
        check("good_hold_data", wr_data, 8'h13);

        // Bad checksum: 02 10 20 31
        pulse_start();
        check("bad_done_cleared", done, 0);
        check("bad_sum_cleared",  checksum, 0);
        put_byte(8'h02);
        put_byte(8'h10);
        put_byte(8'h20);
        put_byte(8'h31);
        @(negedge clock);
        exp_q = '{8'h10, 8'h20};
        check_writes("badsum", exp_q);
        check("badsum_err",      err,      1);
        check("badsum_done",     done,     0);
        check("badsum_checksum", checksum, 8'h30);

        // Bad length 00
        pulse_start();
        check("len0_err_cleared", err, 0);
        put_byte(8'h00);
        @(negedge clock);
        check("len0_writes", log_data.size(), 0);
        check("len0_err",    err,  1);
        check("len0_done",   done, 0);

        // Bad length 22 (> DEPTH)
        pulse_start();
        put_byte(8'h16);
        @(negedge clock);
        check("len22_writes", log_data.size(), 0);
        check("len22_err",    err, 1);

        // Boundary length L = DEPTH with words 1..21, sum 231 = E7
        pulse_start();
        put_byte(8'(DEPTH));
        exp_q = {};
        sum   = '0;
        for (int i = 1; i <= DEPTH; i++) begin
            put_byte(8'(i));
            exp_q.push_back(8'(i));
            sum = sum + 8'(i);
        end
        put_byte(8'hE7);
        @(negedge clock);
        check_writes("depth", exp_q);
        check("depth_sum_const", {24'd0, sum}, 32'hE7);
        check("depth_done", done, 1);

        // Stall and checksum overflow: 02 FF <stall 5> 02 01
        pulse_start();
        put_byte(8'h02);
        put_byte(8'hFF);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_hold%0d", i), cpu_hold, 1);
            @(negedge clock);
        end
        check("stall_ready", in_ready, 1);
        check("stall_sum",   checksum, 8'hFF);
        put_byte(8'h02);
        put_byte(8'h01);
        @(negedge clock);
        exp_q = '{8'hFF, 8'h02};
        check_writes("stall", exp_q);
        check("stall_checksum", checksum, 8'h01);
        check("stall_done",     done, 1);

        // Reset mid-load: reset on the edge that would accept 52
        pulse_start();
        put_byte(8'h03);
        put_byte(8'h41);
        in_valid = 1'b1;
        in_data  = 8'h52;
        reset    = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        check("rstmid_wr_en",    wr_en,    0);
        check("rstmid_ready",    in_ready, 0);
        check("rstmid_hold",     cpu_hold, 0);
        check("rstmid_done",     done,     0);
        check("rstmid_err",      err,      0);
        check("rstmid_checksum", checksum, 0);
        check("rstmid_addr",     wr_addr,  0);
        check("rstmid_data",     wr_data,  0);
        check("rstmid_writes",   log_data.size(), 1);
        reset = 1'b0;
        @(negedge clock);
        check("rstmid_idle_ready", in_ready, 0);

        // Ignored start while in DATA
        pulse_start();
        put_byte(8'h03);
        put_byte(8'h41);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("ignstart_ready", in_ready, 1);
        put_byte(8'h52);
        put_byte(8'h13);
        put_byte(8'hA6);
        @(negedge clock);
        exp_q = '{8'h41, 8'h52, 8'h13};
        check_writes("ignstart", exp_q);
        check("ignstart_done",     done, 1);
        check("ignstart_checksum", checksum, 8'hA6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
